// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive controller: FSM states, data width, default FIFO depth.
package uart_pkg;

  localparam int UART_DATA_W = 8;
  localparam int UART_DEPTH  = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    CAPTURE = 2'd2
  } rx_state_e;

endpackage

// File: rtl/uart_rx_fifo.sv
// First-word-fall-through byte FIFO; pointers carry one extra wrap bit so level = wr_ptr - rd_ptr.
module uart_rx_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LEVEL = (AW+1)'(DEPTH);

  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_wr;
  logic             do_rd;

  assign level = wr_ptr - rd_ptr;
  assign empty = (level == '0);
  assign full  = (level == FULL_LEVEL);

  // A pop frees the slot in the same cycle, so a full FIFO still accepts a simultaneous push.
  assign do_rd = pop && !empty;
  assign do_wr = push && (!full || do_rd);

  assign rdata = empty ? '0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive sequencer: arms the receiver, catches rdy rising edges, buffers bytes for the host.
// Optional idle timeout output is built when UART_RX_TIMEOUT_EN is defined.
module uart_rx_ctrl
  import uart_pkg::*;
#(
  parameter int DEPTH          = UART_DEPTH,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     enable,
  output logic                     rx_en,
  input  logic                     rx_rdy,
  input  logic [UART_DATA_W-1:0]   rx_data,
  output logic [UART_DATA_W-1:0]   out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overrun,
  input  logic                     clr_ovr
`ifdef UART_RX_TIMEOUT_EN
  ,
  output logic                     timeout
`endif
);

  rx_state_e              state;
  rx_state_e              state_nxt;
  logic                   rdy_q;
  logic                   capture;
  logic                   push;
  logic                   pop;
  logic                   full;
  logic                   empty;
  logic [UART_DATA_W-1:0] data_q;

  assign capture   = rx_rdy && !rdy_q && (state == ARMED);
  assign push      = (state == CAPTURE);
  assign pop       = out_ready && !empty;
  assign out_valid = !empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      rdy_q   <= 1'b0;
      rx_en   <= 1'b0;
      data_q  <= '0;
      overrun <= 1'b0;
    end else begin
      state <= state_nxt;
      rdy_q <= rx_rdy;
      // Follows the state one cycle late so the receiver sees a clean registered enable.
      rx_en <= (state != IDLE);
      if (capture) data_q <= rx_data;
      if (push && full && !out_ready) overrun <= 1'b1;
      else if (clr_ovr)               overrun <= 1'b0;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (enable) state_nxt = ARMED;
      ARMED:   if (!enable) state_nxt = IDLE;
               else if (capture) state_nxt = CAPTURE;
      CAPTURE: state_nxt = enable ? ARMED : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  uart_rx_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (UART_DATA_W)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .wdata (data_q),
    .rdata (out_data),
    .full  (full),
    .empty (empty),
    .level (level)
  );

`ifdef UART_RX_TIMEOUT_EN
  localparam logic [15:0] TIMEOUT_LIMIT = 16'(TIMEOUT_CYCLES);

  logic [15:0] idle_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idle_cnt <= '0;
    end else if (push || pop || empty) begin
      idle_cnt <= '0;
    end else if (idle_cnt != TIMEOUT_LIMIT) begin
      idle_cnt <= idle_cnt + 16'd1;
    end
  end

  assign timeout = (idle_cnt == TIMEOUT_LIMIT);
`endif

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Randomized bench for uart_rx_ctrl against a queue-based reference model; timeout checked with UART_RX_TIMEOUT_EN.
module tb_uart_rx_ctrl;

  localparam int DEPTH = 8;
  localparam int TO    = 64;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          enable;
  logic          rx_en;
  logic          rx_rdy;
  logic [7:0]    rx_data;
  logic [7:0]    out_data;
  logic          out_valid;
  logic          out_ready;
  logic [LW-1:0] level;
  logic          overrun;
  logic          clr_ovr;
`ifdef UART_RX_TIMEOUT_EN
  logic          timeout;
`endif

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  // Reference model: receiver listening/busy flags and a byte queue.
  logic [7:0] q[$];
  logic [7:0] m_byte;
  bit         m_listen, m_busy, m_ovr, m_prev_rdy, m_rx_en;
  int         m_idle;

  always #5 clk = ~clk;

  uart_rx_ctrl #(
    .DEPTH          (DEPTH),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .enable    (enable),
    .rx_en     (rx_en),
    .rx_rdy    (rx_rdy),
    .rx_data   (rx_data),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .level     (level),
    .overrun   (overrun),
    .clr_ovr   (clr_ovr)
`ifdef UART_RX_TIMEOUT_EN
    ,
    .timeout   (timeout)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model_reset();
    q.delete();
    m_byte = '0; m_listen = 0; m_busy = 0; m_ovr = 0;
    m_prev_rdy = 0; m_rx_en = 0; m_idle = 0;
  endfunction

  function automatic void model_step();
    bit pop_ok    = out_ready && (q.size() > 0);
    bit was_empty = (q.size() == 0);
    bit push      = m_busy;
    bit ovr_set   = 0;
    if (pop_ok) void'(q.pop_front());
    if (push) begin
      if (q.size() < DEPTH) q.push_back(m_byte);
      else ovr_set = 1;
    end
    if (ovr_set) m_ovr = 1;
    else if (clr_ovr) m_ovr = 0;
    if (push || pop_ok || was_empty) m_idle = 0;
    else if (m_idle < TO) m_idle++;
    m_rx_en = m_listen || m_busy;
    if (m_busy) begin
      m_busy = 0;
      m_listen = enable;
    end else if (m_listen) begin
      if (!enable) m_listen = 0;
      else if (rx_rdy && !m_prev_rdy) begin
        m_busy = 1; m_listen = 0; m_byte = rx_data;
      end
    end else begin
      m_listen = enable;
    end
    m_prev_rdy = rx_rdy;
  endfunction

  task automatic compare_all();
    check("rx_en", rx_en, m_rx_en);
    check("out_valid", out_valid, q.size() > 0);
    check("out_data", out_data, (q.size() > 0) ? q[0] : 8'h00);
    check("level", level, q.size());
    check("overrun", overrun, m_ovr);
`ifdef UART_RX_TIMEOUT_EN
    check("timeout", timeout, m_idle == TO);
`endif
  endtask

  task automatic step(input logic en, input logic rdy, input logic [7:0] d,
                      input logic rd, input logic clr);
    enable = en; rx_rdy = rdy; rx_data = d; out_ready = rd; clr_ovr = clr;
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_all();
  endtask

  // Reset asserted mid-cycle so the zeroed outputs can only come from the asynchronous path.
  task automatic do_reset();
    #2 rst_n = 1'b0;
    #1;
    check("rst_rx_en", rx_en, 1'b0);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_data", out_data, 8'h00);
    check("rst_level", level, '0);
    check("rst_overrun", overrun, 1'b0);
`ifdef UART_RX_TIMEOUT_EN
    check("rst_timeout", timeout, 1'b0);
`endif
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; enable = 0; rx_rdy = 0; rx_data = '0; out_ready = 0; clr_ovr = 0;
    model_reset();
    repeat (2) @(negedge clk);
    compare_all();
    rst_n = 1'b1;

    // Mid-stream reset with bytes buffered, then receiver must stay disabled.
    step(1, 0, 8'h00, 0, 0);
    for (int unsigned i = 0; i < 3; i++) begin
      step(1, 1, 8'h50 + 8'(i), 0, 0);
      step(1, 0, 8'h00, 0, 0);
    end
    do_reset();
    for (int unsigned i = 0; i < 4; i++) begin
      step(0, 1'(i), 8'h77, 0, 0);
      check("idle_rx_en", rx_en, 1'b0);
    end

    // Single byte, two edges from rdy rise to head of FIFO.
    step(1, 0, 8'h00, 0, 0);
    step(1, 1, 8'h1C, 0, 0);
    step(1, 0, 8'h00, 0, 0);
    check("t2_valid", out_valid, 1'b1);
    check("t2_data", out_data, 8'h1C);
    check("t2_level", level, 1);
    step(1, 0, 8'h00, 1, 0);
    check("t2_level_pop", level, 0);

    // Overflow with nine bytes, then drain in order and clear.
    for (int unsigned i = 1; i <= 9; i++) begin
      step(1, 1, 8'(i), 0, 0);
      step(1, 0, 8'h00, 0, 0);
    end
    check("t3_level", level, DEPTH);
    check("t3_overrun", overrun, 1'b1);
    for (int unsigned i = 1; i <= 8; i++) begin
      check("t3_pop_data", out_data, 8'(i));
      step(1, 0, 8'h00, 1, 0);
    end
    step(1, 0, 8'h00, 0, 1);
    check("t3_clr", overrun, 1'b0);

    // Push and pop together while full.
    for (int unsigned i = 0; i < 8; i++) begin
      step(1, 1, 8'hA0 + 8'(i), 0, 0);
      step(1, 0, 8'h00, 0, 0);
    end
    step(1, 1, 8'hAA, 0, 0);
    step(1, 0, 8'h00, 1, 0);
    check("t4_level", level, DEPTH);
    check("t4_overrun", overrun, 1'b0);
    check("t4_head", out_data, 8'hA1);
    for (int unsigned i = 0; i < 8; i++) step(1, 0, 8'h00, 1, 0);

    // rdy already high when arming, and disable while armed.
    step(0, 0, 8'h00, 0, 0);
    step(0, 1, 8'h33, 0, 0);
    step(1, 1, 8'h33, 0, 0);
    step(1, 1, 8'h33, 0, 0);
    step(1, 1, 8'h33, 0, 0);
    check("t5_no_push", level, 0);
    step(1, 0, 8'h00, 0, 0);
    step(0, 1, 8'h44, 0, 0);
    step(0, 0, 8'h00, 0, 0);
    check("t5_rx_en", rx_en, 1'b0);
    step(0, 0, 8'h00, 0, 0);
    check("t5_no_push2", level, 0);

`ifdef UART_RX_TIMEOUT_EN
    step(1, 0, 8'h00, 0, 0);
    step(1, 1, 8'h5A, 0, 0);
    step(1, 0, 8'h00, 0, 0);
    for (int unsigned i = 0; i < TO - 1; i++) step(1, 0, 8'h00, 0, 0);
    check("t6_before", timeout, 1'b0);
    step(1, 0, 8'h00, 0, 0);
    check("t6_timeout", timeout, 1'b1);
    step(1, 0, 8'h00, 1, 0);
    check("t6_cleared", timeout, 1'b0);
`endif

    // Randomized traffic with occasional resets.
    for (int unsigned i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 499) == 0) begin
        do_reset();
      end else begin
        step($urandom_range(0, 15) != 0,
             ($urandom_range(0, 2) == 0) ? ~rx_rdy : rx_rdy,
             8'($urandom),
             $urandom_range(0, 2) == 0,
             $urandom_range(0, 15) == 0);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
